div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the subtractive counterpart of the execute-stage adder/subtractor: a restoring radix-2 divider that retires one quotient bit per clock. It sits beside the ALU in the execute stage. While `busy_o` is high, the pipeline stalls on it; it captures `result_o` when `valid_o` pulses.

---
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per clock. Divide-by-zero and signed overflow
// are resolved in a single cycle without entering the iteration.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] opera_i,
  input  logic [XLEN-1:0] operb_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic            rem_sel_q, rem_sel_d;    // op_i[1]: select remainder
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN:0]   rem_q, rem_d;            // partial remainder, 33 bits
  logic [XLEN-1:0] quo_q, quo_d;            // dividend in, quotient out
  logic [XLEN-1:0] div_q, div_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand conditioning: op_i[0] set means unsigned.
  logic            is_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_by_zero, sgn_overflow;

  assign is_signed    = ~op_i[0];
  assign a_neg        = is_signed & opera_i[XLEN-1];
  assign b_neg        = is_signed & operb_i[XLEN-1];
  assign a_abs        = a_neg ? -opera_i : opera_i;
  assign b_abs        = b_neg ? -operb_i : operb_i;
  assign div_by_zero  = (operb_i == '0);
  assign sgn_overflow = is_signed & (opera_i == MIN_NEG) & (operb_i == '1);

  // One restoring step: shift {rem, quo} left and try subtracting the divisor.
  // The extra top bit of trial is the borrow; rem < divisor keeps it exact.
  logic [XLEN+1:0] trial;
  logic            trial_ok;
  logic [XLEN:0]   rem_step;
  logic [XLEN-1:0] quo_step;

  assign trial    = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, div_q};
  assign trial_ok = ~trial[XLEN+1];
  assign rem_step = trial_ok ? trial[XLEN:0] : {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign quo_step = {quo_q[XLEN-2:0], trial_ok};

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        // A flush in IDLE drops any concurrent request.
        if (start_i && !flush_i) begin
          rem_sel_d = op_i[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rem_d     = '0;
          quo_d     = a_abs;
          div_d     = b_abs;
          if (div_by_zero) begin
            result_d = op_i[1] ? opera_i : '1;
            state_d  = S_DONE;
          end else if (sgn_overflow) begin
            result_d = op_i[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            cnt_d   = 5'd31;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            // Sign fix-up lands in result_o on the edge that enters DONE.
            if (rem_sel_q) result_d = neg_rem_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
            else           result_d = neg_quo_q ? -quo_step : quo_step;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State register; asynchronous reset clears everything, including result_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int         BUDGET  = 40;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] opera_i = '0;
  logic [31:0] operb_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_cmp  = 0;
  int n_fail = 0;

  div_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .opera_i  (opera_i),
    .operb_i  (operb_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and follow it until valid_o or the cycle budget.
  // inj_start / inj_flush pulse start_i / flush_i during the given cycle.
  // On completion the task waits one more edge so the unit is back in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_start, input int inj_flush,
                        output logic [31:0] res, output int lat, output int busy_n,
                        output bit got);
    res = '0; busy_n = 0; got = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; opera_i = a; operb_i = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    lat = 1;
    while (!got && lat <= BUDGET) begin
      if (busy_o) busy_n++;
      if (valid_o) begin
        got = 1'b1;
        res = result_o;
      end else begin
        start_i = (lat == inj_start);
        if (lat == inj_start) begin
          op_i = OP_DIVU; opera_i = 32'd1000; operb_i = 32'd3;
        end
        flush_i = (lat == inj_flush);
        @(posedge clk_i);
        #1;
        lat++;
      end
    end
    start_i = 1'b0;
    flush_i = 1'b0;
    if (got) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  vec_t        vecs[16];
  logic [31:0] res;
  int          lat;
  int          busy_n;
  bit          got;
  logic [31:0] prior;

  initial begin
    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,        32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,         33};
    vecs[6]  = '{OP_DIV,  32'h1234_5678,  32'd0,        32'hFFFF_FFFF,  1};
    vecs[7]  = '{OP_DIVU, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF,  1};
    vecs[8]  = '{OP_REM,  32'h1234_5678,  32'd0,        32'h1234_5678,  1};
    vecs[9]  = '{OP_REMU, 32'h1234_5678,  32'd0,        32'h1234_5678,  1};
    vecs[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    // Same bit patterns unsigned are ordinary divisions.
    vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
    vecs[13] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[14] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        33};
    vecs[15] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 33};

    // Reset state.
    #12;
    check("reset busy",   {31'd0, busy_o},  32'd0);
    check("reset valid",  {31'd0, valid_o}, 32'd0);
    check("reset result", result_o,         32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, res, lat, busy_n, got);
      check($sformatf("vec%0d got", i),     {31'd0, got}, 32'd1);
      check($sformatf("vec%0d result", i),  res,          vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat,          vecs[i].lat);
      check($sformatf("vec%0d busy", i),    busy_n,       vecs[i].lat);
      check($sformatf("vec%0d idle", i),    {30'd0, busy_o, valid_o}, 32'd0);
    end

    // Flush at CALC cycle 10: back to IDLE, no valid, result unchanged.
    prior = result_o;
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 10, res, lat, busy_n, got);
    check("flush no valid", {31'd0, got}, 32'd0);
    check("flush busy",     busy_n,       10);
    check("flush result",   result_o,     prior);
    check("flush idle",     {30'd0, busy_o, valid_o}, 32'd0);

    // start_i pulse during CALC is ignored.
    run_op(OP_DIVU, 32'd100, 32'd7, 5, 0, res, lat, busy_n, got);
    check("ignstart result",  res, 32'd14);
    check("ignstart latency", lat, 33);
    check("ignstart idle",    {30'd0, busy_o, valid_o}, 32'd0);

    // Asynchronous reset mid-CALC.
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; opera_i = 32'd999; operb_i = 32'd10;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #2;
    check("pre-reset busy",   {31'd0, busy_o}, 32'd1);
    check("pre-reset result", result_o,        32'd14);
    rst_i = 1'b1;
    #1;
    check("async rst busy",   {31'd0, busy_o},  32'd0);
    check("async rst valid",  {31'd0, valid_o}, 32'd0);
    check("async rst result", result_o,         32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Back-to-back: second request issued in the first IDLE cycle after valid.
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, 0, res, lat, busy_n, got);
    check("b2b first result",  res, 32'hFFFF_FFFF);
    check("b2b first latency", lat, 33);
    run_op(OP_REMU, 32'd5, 32'd3, 0, 0, res, lat, busy_n, got);
    check("b2b second result",  res, 32'd2);
    check("b2b second latency", lat, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
